// File: rtl/reg_read_seq.sv
// Two-cycle operand read sequencer for a single-port register file, with write snooping.
// Build option: define RD_FWD_EN for write-first forwarding of same-cycle register writes.
module reg_read_seq #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [WIDTH-1:0]  rf_rdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_a,
  output logic [WIDTH-1:0]  rsp_b
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD_A = 2'd1;
  localparam logic [1:0] RD_B = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [WIDTH-1:0]  rsp_a_q, rsp_a_d;
  logic [WIDTH-1:0]  rsp_b_q, rsp_b_d;
  logic [WIDTH-1:0]  rd_val;

  always_comb begin
    rf_raddr = '0;
    case (state_q)
      RD_A:    rf_raddr = addr_a_q;
      RD_B:    rf_raddr = addr_b_q;
      default: rf_raddr = '0;
    endcase
  end

`ifdef RD_FWD_EN
  // A write landing on the address being read this cycle wins over the stale array value.
  assign rd_val = (wr_en && (wr_addr == rf_raddr)) ? wr_data : rf_rdata;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign rd_val    = rf_rdata;
`endif

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    rsp_a_d  = rsp_a_q;
    rsp_b_d  = rsp_b_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_a_d = req_addr_a;
          addr_b_d = req_addr_b;
          state_d  = RD_A;
        end
      end
      RD_A: begin
        rsp_a_d = rd_val;
        state_d = RD_B;
      end
      RD_B: begin
        rsp_b_d = rd_val;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      rsp_a_q  <= '0;
      rsp_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      rsp_a_q  <= rsp_a_d;
      rsp_b_q  <= rsp_b_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;

endmodule

// File: tb/tb_reg_read_seq.sv
// Scoreboard bench for reg_read_seq; honours RD_FWD_EN the same way as the design build.
module tb_reg_read_seq;
  localparam int WIDTH  = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr_a, req_addr_b, rf_raddr, wr_addr;
  logic [WIDTH-1:0]  rf_rdata, wr_data, rsp_a, rsp_b;
  logic              wr_en, rsp_valid, rsp_ready;

  logic [WIDTH-1:0]  rf [16];
  logic [7:0]        exp_q [$];
  int                total = 0;
  int                bad   = 0;
  int                n_rsp = 0;

  always #5 clk = ~clk;

  reg_read_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b)
  );

  // Register-file model: combinational read, write at the clock edge.
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every completed handshake.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      logic [7:0] e;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_rsp++;
        $display("rsp %0d: a=%h b=%h exp_a=%h exp_b=%h", n_rsp, rsp_a, rsp_b, e[7:4], e[3:0]);
        chk("rsp_a", 32'(rsp_a), 32'(e[7:4]));
        chk("rsp_b", 32'(rsp_b), 32'(e[3:0]));
      end
    end
  end

  task automatic rf_wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // One request: optional write during RD_A, bp cycles of backpressure, optional write to A during RESP.
  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input bit wen, input logic [3:0] waddr, input logic [3:0] wdata,
                       input int bp, input bit resp_wr, input logic [3:0] resp_wdata);
    logic [3:0] ea, eb;
    ea = rf[a];
`ifdef RD_FWD_EN
    if (wen && waddr == a) ea = wdata;
`endif
    eb = (wen && waddr == b) ? wdata : rf[b];
    exp_q.push_back({ea, eb});
    rsp_ready = (bp == 0);
    req_valid = 1'b1; req_addr_a = a; req_addr_b = b;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step();                                  // edge N: accepted
    req_valid = 1'b0; req_addr_a = ~a; req_addr_b = ~b;
    chk("raddr_a", 32'(rf_raddr), 32'(a));
    chk("req_ready_rda", 32'(req_ready), 32'd0);
    wr_en = wen; wr_addr = waddr; wr_data = wdata;
    step();                                  // edge N+1: A captured
    wr_en = 1'b0;
    chk("raddr_b", 32'(rf_raddr), 32'(b));
    chk("valid_early", 32'(rsp_valid), 32'd0);
    step();                                  // edge N+2: response valid
    chk("valid_lat", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      wr_en = resp_wr && (i == 0); wr_addr = a; wr_data = resp_wdata;
      step();
      wr_en = 1'b0;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_a", 32'(rsp_a), 32'(ea));
      chk("bp_b", 32'(rsp_b), 32'(eb));
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();                                  // handshake edge
    rsp_ready = 1'b0;
    chk("idle_back", 32'(req_ready), 32'd1);
    chk("valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
    req_addr_a = '0; req_addr_b = '0; wr_addr = '0; wr_data = '0;
    step(); step();
    rst = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_a", 32'(rsp_a), 32'd0);
    chk("rst_rsp_b", 32'(rsp_b), 32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);

    for (int i = 0; i < 16; i++) rf_wr(4'(i), 4'(i * 7 + 2));
    rf_wr(4'd3, 4'hA); rf_wr(4'd7, 4'h5);
    rf_wr(4'd2, 4'h1); rf_wr(4'd1, 4'h3);

    // basic read, then backpressure on the same registers
    issue(4'd3, 4'd7, 1'b0, 4'd0, 4'd0, 0, 1'b0, 4'd0);
    issue(4'd3, 4'd7, 1'b0, 4'd0, 4'd0, 5, 1'b0, 4'd0);

    // same-cycle write to R2 while reading it as operand A
    issue(4'd2, 4'd2, 1'b1, 4'd2, 4'hF, 1, 1'b0, 4'd0);
`ifdef RD_FWD_EN
    chk("samecyc_a_direct", 32'(rsp_a), 32'hF);
`else
    chk("samecyc_a_direct", 32'(rsp_a), 32'h1);
`endif
    chk("samecyc_b_direct", 32'(rsp_b), 32'hF);

    // post-capture write to R1 during RESP must not disturb the snapshot
    issue(4'd1, 4'd7, 1'b0, 4'd0, 4'd0, 3, 1'b1, 4'hC);
    chk("postcap_a_direct", 32'(rsp_a), 32'h3);
    chk("postcap_rf_model", 32'(rf[1]), 32'hC);

    // reset while in RD_B discards the request
    req_valid = 1'b1; req_addr_a = 4'd3; req_addr_b = 4'd7; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("midrst_in_rdb", 32'(rf_raddr), 32'd7);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_a", 32'(rsp_a), 32'd0);
    chk("midrst_b", 32'(rsp_b), 32'd0);
    chk("midrst_raddr", 32'(rf_raddr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    // random mix of requests, snooped writes and backpressure
    for (int i = 0; i < 20; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
